// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants, LRCK polarity and frame-counter sizing
package i2s_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_SLOT_WIDTH = 16;

   localparam logic LEFT_SLOT  = 1'b0;
   localparam logic RIGHT_SLOT = 1'b1;

   function automatic int frame_cnt_width(input int slot_width);
      return $clog2(2 * slot_width);
   endfunction

endpackage

// File: rtl/i2s_frame_timer.sv
// rtl/i2s_frame_timer.sv - I2S frame counter with registered LRCK, slot position and transfer strobe
module i2s_frame_timer
   import i2s_pkg::*;
#(
   parameter int SLOT_WIDTH = DEFAULT_SLOT_WIDTH,
   localparam int CW = frame_cnt_width(SLOT_WIDTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          lrck,
   output logic [CW-1:0] slot_pos,
   output logic          xfer
);

   localparam logic [CW-1:0] LAST = CW'(2 * SLOT_WIDTH - 1);
   localparam logic [CW-1:0] SLOT = CW'(SLOT_WIDTH);

   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   assign count_next = (count == LAST) ? '0 : count + CW'(1);

   // LRCK is derived from the next count so it lines up with the count it describes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         lrck  <= LEFT_SLOT;
      end else begin
         count <= count_next;
         lrck  <= (count_next >= SLOT) ? RIGHT_SLOT : LEFT_SLOT;
      end
   end

   assign slot_pos = (lrck == RIGHT_SLOT) ? count - SLOT : count;
   assign xfer     = (count == LAST);

endmodule

// File: rtl/i2s_serializer.sv
// rtl/i2s_serializer.sv - I2S frame-master transmitter with one-pair holding buffer and underrun tracking
module i2s_serializer
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int SLOT_WIDTH = DEFAULT_SLOT_WIDTH
) (
   input  logic                  BCLK,
   input  logic                  RESET_N,
   input  logic [DATA_WIDTH-1:0] LEFT_CHANNEL,
   input  logic [DATA_WIDTH-1:0] RIGHT_CHANNEL,
   input  logic                  SAMPLE_VALID,
   output logic                  SAMPLE_READY,
   output logic                  LRCK,
   output logic                  AUD_OUT,
   output logic                  UNDERRUN,
   output logic [7:0]            UNDERRUN_COUNT
);

   localparam int CW = frame_cnt_width(SLOT_WIDTH);
   localparam int FW = 2 * DATA_WIDTH;
   localparam logic [CW-1:0] DLIM = CW'(DATA_WIDTH);

   logic [CW-1:0]         slot_pos;
   logic                  xfer;
   logic                  full;
   logic [DATA_WIDTH-1:0] hold_l;
   logic [DATA_WIDTH-1:0] hold_r;
   logic [FW-1:0]         frame_sr;
   logic                  handshake;
   logic                  in_data;
   logic                  cur_bit;

   i2s_frame_timer #(
      .SLOT_WIDTH (SLOT_WIDTH)
   ) u_timer (
      .clk      (BCLK),
      .rst_n    (RESET_N),
      .lrck     (LRCK),
      .slot_pos (slot_pos),
      .xfer     (xfer)
   );

   assign SAMPLE_READY = !full;
   assign handshake    = SAMPLE_VALID && !full;
   // shifter only advances during data bits; slot padding transmits zeros
   assign in_data      = (slot_pos < DLIM);
   assign cur_bit      = in_data ? frame_sr[FW-1] : 1'b0;

   always_ff @(posedge BCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         full           <= 1'b0;
         hold_l         <= '0;
         hold_r         <= '0;
         frame_sr       <= '0;
         AUD_OUT        <= 1'b0;
         UNDERRUN       <= 1'b0;
         UNDERRUN_COUNT <= 8'd0;
      end else begin
         AUD_OUT  <= cur_bit;
         UNDERRUN <= 1'b0;
         if (xfer) begin
            full <= 1'b0;
            if (full) begin
               frame_sr <= {hold_l, hold_r};
            end else if (handshake) begin
               frame_sr <= {LEFT_CHANNEL, RIGHT_CHANNEL};
            end else begin
               frame_sr <= '0;
               UNDERRUN <= 1'b1;
               if (UNDERRUN_COUNT != 8'hFF) begin
                  UNDERRUN_COUNT <= UNDERRUN_COUNT + 8'd1;
               end
            end
         end else begin
            if (in_data) begin
               frame_sr <= {frame_sr[FW-2:0], 1'b0};
            end
            if (handshake) begin
               hold_l <= LEFT_CHANNEL;
               hold_r <= RIGHT_CHANNEL;
               full   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_serializer.sv
// tb/tb_i2s_serializer.sv - randomized self-checking bench for i2s_serializer against a frame-level model
module tb_i2s_serializer;

   localparam int DW = 16;
   localparam int SW = 16;
   localparam int F  = 2 * SW;

   logic          bclk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] lch, rch;
   logic          valid;
   logic          ready, lrck, aud, und;
   logic [7:0]    ucnt;

   logic          rst2_n;
   logic [15:0]   l2, r2;
   logic          v2;
   logic          ready2, lrck2, aud2, und2;
   logic [7:0]    cnt2;

   always #5 bclk = ~bclk;

   i2s_serializer #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
      .BCLK(bclk), .RESET_N(rst_n), .LEFT_CHANNEL(lch), .RIGHT_CHANNEL(rch),
      .SAMPLE_VALID(valid), .SAMPLE_READY(ready), .LRCK(lrck), .AUD_OUT(aud),
      .UNDERRUN(und), .UNDERRUN_COUNT(ucnt)
   );

   i2s_serializer #(.DATA_WIDTH(16), .SLOT_WIDTH(24)) dut24 (
      .BCLK(bclk), .RESET_N(rst2_n), .LEFT_CHANNEL(l2), .RIGHT_CHANNEL(r2),
      .SAMPLE_VALID(v2), .SAMPLE_READY(ready2), .LRCK(lrck2), .AUD_OUT(aud2),
      .UNDERRUN(und2), .UNDERRUN_COUNT(cnt2)
   );

   int total  = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
   endtask

   // frame-level model: which pair each frame carries, buffer occupancy, underrun bookkeeping
   int            mc;
   logic [DW-1:0] cur_l, cur_r, prev_l, prev_r, hold_l, hold_r;
   logic          full_m, und_m, hs;
   int            cnt_m;

   always @(posedge bclk or negedge rst_n) begin
      if (!rst_n) begin
         mc = 0; cur_l = '0; cur_r = '0; prev_l = '0; prev_r = '0;
         hold_l = '0; hold_r = '0; full_m = 1'b0; und_m = 1'b0; cnt_m = 0;
      end else begin
         hs    = valid && !full_m;
         und_m = 1'b0;
         if (mc == F - 1) begin
            prev_l = cur_l; prev_r = cur_r;
            if (full_m) begin
               cur_l = hold_l; cur_r = hold_r; full_m = 1'b0;
            end else if (hs) begin
               cur_l = lch; cur_r = rch;
            end else begin
               cur_l = '0; cur_r = '0; und_m = 1'b1;
               if (cnt_m < 255) cnt_m++;
            end
            mc = 0;
         end else begin
            if (hs) begin
               hold_l = lch; hold_r = rch; full_m = 1'b1;
            end
            mc++;
         end
      end
   end

   function automatic logic slot_bit(input logic [DW-1:0] l, input logic [DW-1:0] r, input int k);
      int j;
      j = k % SW;
      if (j >= DW) return 1'b0;
      return (k >= SW) ? r[DW-1-j] : l[DW-1-j];
   endfunction

   function automatic logic exp_aud();
      if (mc == 0) return slot_bit(prev_l, prev_r, F - 1);
      return slot_bit(cur_l, cur_r, mc - 1);
   endfunction

   always @(negedge bclk) begin
      if (rst_n === 1'b1) begin
         chk("lrck", {31'd0, lrck}, {31'd0, mc >= SW});
         chk("aud_out", {31'd0, aud}, {31'd0, exp_aud()});
         chk("ready", {31'd0, ready}, {31'd0, !full_m});
         chk("underrun", {31'd0, und}, {31'd0, und_m});
         chk("underrun_count", {24'd0, ucnt}, cnt_m);
      end
   end

   task automatic tick();
      @(posedge bclk);
      #1;
   endtask

   task automatic wait_c(input int target);
      int n;
      n = 0;
      while (mc != target && n < 200) begin
         tick();
         n++;
      end
      if (mc != target) begin
         total++;
         $display("FAIL wait_c: cycle %0d not reached, at %0d", target, mc);
      end
   endtask

   task automatic capture_frame(output logic [31:0] v, output logic l15, output logic l16);
      v = '0; l15 = 1'b0; l16 = 1'b0;
      for (int i = 0; i < 32; i++) begin
         tick();
         v[31-i] = aud;
         if (i == 14) l15 = lrck;
         if (i == 15) l16 = lrck;
      end
   endtask

   logic [31:0] vec;
   logic        lr15, lr16;
   int          acc;

   initial begin
      rst_n = 1'b0; valid = 1'b0; lch = '0; rch = '0;
      repeat (2) @(negedge bclk);
      chk("rst_lrck", {31'd0, lrck}, 32'd0);
      chk("rst_aud", {31'd0, aud}, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_underrun", {31'd0, und}, 32'd0);
      chk("rst_count", {24'd0, ucnt}, 32'd0);
      rst_n = 1'b1;

      // idle: frame 0 silent, underruns at start of frames 1 and 2
      repeat (2 * F) tick();
      chk("idle_underrun_f2", {31'd0, und}, 32'd1);
      chk("idle_count_f2", {24'd0, ucnt}, 32'd2);

      wait_c(5);
      valid = 1'b1; lch = 16'hA5C3; rch = 16'h0F0F;
      tick();
      valid = 1'b0;
      chk("ready_after_accept", {31'd0, ready}, 32'd0);
      wait_c(0);
      chk("no_underrun_loaded", {31'd0, und}, 32'd0);
      capture_frame(vec, lr15, lr16);
      chk("frame_a5c3_0f0f", vec, 32'hA5C30F0F);
      chk("lrck_c15", {31'd0, lr15}, 32'd0);
      chk("lrck_c16", {31'd0, lr16}, 32'd1);

      // streaming: new pair every cycle, one acceptance per frame
      acc = 0;
      valid = 1'b1;
      for (int i = 0; i < 8 * F; i++) begin
         lch = DW'($urandom); rch = DW'($urandom);
         if (ready) acc++;
         tick();
      end
      valid = 1'b0;
      chk("stream_accepts", acc, 32'd8);
      chk("stream_count", {24'd0, ucnt}, 32'd3);

      for (int i = 0; i < 40 * F; i++) begin
         valid = ($urandom_range(0, 15) == 0);
         lch = DW'($urandom); rch = DW'($urandom);
         tick();
      end
      valid = 1'b0;

      repeat (260 * F) tick();
      chk("count_saturated", {24'd0, ucnt}, 32'd255);

      // handshake exactly in the transfer cycle with the buffer empty
      wait_c(F - 1);
      valid = 1'b1; lch = 16'hC001; rch = 16'h0003;
      tick();
      valid = 1'b0;
      chk("bypass_no_underrun", {31'd0, und}, 32'd0);
      capture_frame(vec, lr15, lr16);
      chk("bypass_frame", vec, 32'hC0010003);

      // reset mid-frame while the buffer is full
      wait_c(3);
      valid = 1'b1; lch = 16'hFFFF; rch = 16'hFFFF;
      tick();
      valid = 1'b0;
      wait_c(10);
      chk("full_before_reset", {31'd0, ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("async_lrck", {31'd0, lrck}, 32'd0);
      chk("async_aud", {31'd0, aud}, 32'd0);
      chk("async_ready", {31'd0, ready}, 32'd1);
      chk("async_count", {24'd0, ucnt}, 32'd0);
      chk("async_underrun", {31'd0, und}, 32'd0);
      @(negedge bclk);
      rst_n = 1'b1;
      capture_frame(vec, lr15, lr16);
      chk("post_reset_silent", vec, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // 24-bit slots, 16-bit data: padding bits must be zero
   initial begin
      rst2_n = 1'b0; v2 = 1'b0; l2 = 16'hFFFF; r2 = 16'h8001;
      repeat (2) @(negedge bclk);
      rst2_n = 1'b1;
      repeat (3) @(posedge bclk);
      #1;
      v2 = 1'b1;
      @(posedge bclk);
      #1;
      v2 = 1'b0;
      repeat (44) @(posedge bclk);
      for (int k = 0; k < 48; k++) begin
         @(negedge bclk);
         chk("w24_aud", {31'd0, aud2}, {31'd0, ((k >= 1 && k <= 16) || k == 25 || k == 40)});
         chk("w24_lrck", {31'd0, lrck2}, {31'd0, k >= 24});
         if (k == 0) begin
            chk("w24_underrun", {31'd0, und2}, 32'd0);
            chk("w24_count", {24'd0, cnt2}, 32'd0);
            chk("w24_ready", {31'd0, ready2}, 32'd1);
         end
         @(posedge bclk);
      end
   end

endmodule

// File: doc/i2s_serializer.md
# i2s_serializer

I2S transmitter: accepts left/right sample pairs over a valid/ready handshake and shifts them out MSB-first as standard I2S (one-BCLK data delay after each LRCK edge), acting as frame master, i.e. driving LRCK. It is the transmit counterpart of the I2S deserializer on the codec DAC path (DACDAT/DACLRCK). It is one-entry buffered so upstream logic has a full frame to deliver the next pair.

## Interface
- DATA_WIDTH, 16, sample width per channel
- SLOT_WIDTH, 16, BCLK periods per channel slot; must be ≥ DATA_WIDTH. Frame length is 2·SLOT_WIDTH.
- BCLK  in  1  bit clock; the only clock, all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- LEFT_CHANNEL  in  DATA_WIDTH  left sample, two's complement
- RIGHT_CHANNEL  in  DATA_WIDTH  right sample
- SAMPLE_VALID  in  1  pair on LEFT/RIGHT_CHANNEL is valid
- SAMPLE_READY  out  1  holding buffer empty; pair accepted when VALID && READY at a rising edge
- LRCK  out  1  0 = left slot, 1 = right slot
- AUD_OUT  out  1  serial data
- UNDERRUN  out  1  one-cycle pulse: frame started with no new pair
- UNDERRUN_COUNT  out  8  saturating count of underruns

## Operation
- Frame counter c runs 0..2·SLOT_WIDTH−1, then wraps to 0. LRCK = 0 for c < SLOT_WIDTH, 1 otherwise; LRCK is registered.
- Serial stream s(k), k = slot-relative index:
  - left slot: s(k) = L[DATA_WIDTH−1−k] for k < DATA_WIDTH, else 0
  - right slot: same rule with R
- AUD_OUT at counter c carries s(c−1), with c−1 taken modulo the frame. Thus the first cycle of each slot carries the last bit of the previous slot (I2S one-bit delay).
- Holding buffer: one pair plus a full flag. SAMPLE_READY = !full.
- Transfer cycle is c = 2·SLOT_WIDTH−1, the last cycle of the frame. In that cycle the frame register loads the holding pair, and full clears.
- If the buffer is empty in the transfer cycle:
  - when VALID && READY in that same cycle, the incoming pair bypasses directly into the frame register; no underrun.
  - otherwise the frame register loads zeros, UNDERRUN pulses high for the first cycle of the new frame (c = 0), and UNDERRUN_COUNT increments, saturating at 255.
- A handshake outside the transfer cycle sets full; READY falls the next cycle.
- A handshake in the transfer cycle with the buffer full cannot happen, because READY = 0.
- The input pair is captured atomically; LEFT/RIGHT_CHANNEL are not sampled otherwise.

## Timing
- Reset values (asynchronous, RESET_N low): c = 0, LRCK = 0, AUD_OUT = 0, SAMPLE_READY = 1, full = 0, frame register = 0, UNDERRUN = 0, UNDERRUN_COUNT = 0.
- First frame after reset transmits silence and raises no underrun. Underrun detection is armed from the first transfer cycle onward.
- Latency: a pair accepted in frame N is transmitted in frame N+1. The left MSB appears on AUD_OUT at c = 1; the right MSB appears at c = SLOT_WIDTH+1.
- Throughput: one pair per frame, 2·SLOT_WIDTH BCLKs.
- READY rises the cycle after a transfer cycle that emptied the buffer.
- Reset mid-frame aborts the frame immediately: outputs go to reset values and the buffered pair is discarded. Operation resumes at c = 0 after RESET_N deasserts.
- UNDERRUN_COUNT changes only on UNDERRUN cycles.

## Structure
- Shared package i2s_pkg holds:
  - default DATA_WIDTH and SLOT_WIDTH constants
  - the frame-counter width function, clog2(2·SLOT_WIDTH)
  - the LRCK polarity constants LEFT_SLOT = 0 and RIGHT_SLOT = 1
- One sub-module, i2s_frame_timer, contains the counter, the registered LRCK, the slot-position output and the transfer-cycle strobe. The deserializer can reuse it.
- Top level holds the holding buffer, the shift register with its one-bit delay stage, and the underrun logic.

## Test plan
- Reset, no VALID for 3 frames → frame 0 is silent with no UNDERRUN. UNDERRUN pulses at c = 0 of frames 1 and 2. UNDERRUN_COUNT = 2 and AUD_OUT stays 0.
- Accept L = 16'hA5C3, R = 16'h0F0F at c = 5 → READY falls at c = 6. Next frame: AUD_OUT bits at c = 1..16 read 1010010111000011, LRCK rises at c = 16, and c = 17..32 read 0000111100001111.
- VALID held high with a new pair offered every cycle → exactly one pair accepted per 32 BCLKs, no underrun, consecutive frames carry consecutive pairs.
- Buffer empty, handshake exactly in transfer cycle c = 31 → the pair is transmitted in the immediately following frame, and UNDERRUN stays 0.
- SLOT_WIDTH = 24, DATA_WIDTH = 16, L = 16'hFFFF → AUD_OUT is 1 for c = 1..16 and 0 for c = 17..24.
- RESET_N pulsed low at c = 10 while full → LRCK, AUD_OUT and UNDERRUN_COUNT return to 0 and READY returns to 1 asynchronously. The next frame is silent.
